// File: rtl/entry_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : entry_scan_ctrl_if
// Brief    : Handshake bundle between the scan controller and the entry checker.
// Revision : 1.0 - initial release
// ============================================================================
interface entry_scan_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] ent_data;
  logic [WIDTH-1:0] key_out;
  logic             chk_valid;
  logic             chk_ready;
  logic             chk_match;

  modport master (
    output sel,
    output ent_data,
    output key_out,
    output chk_valid,
    input  chk_ready,
    input  chk_match
  );

  modport slave (
    input  sel,
    input  ent_data,
    input  key_out,
    input  chk_valid,
    output chk_ready,
    output chk_match
  );
endinterface
`default_nettype wire

// File: rtl/entry_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : entry_scan_ctrl
// Brief    : Owns a 4-entry record table and walks it through the downstream
//            entry checker, reporting first match index and match count.
// Revision : 1.0 - initial release
// ============================================================================
module entry_scan_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             wr_en,
  input  wire logic [1:0]       wr_idx,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             inv_all,
  input  wire logic             start,
  input  wire logic [WIDTH-1:0] key,
  input  wire logic             abort,
  entry_scan_ctrl_if.master     chk,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic [1:0]            hit_idx,
  output logic [2:0]            match_cnt,
  output logic                  wr_drop
);

  localparam logic [1:0] c_LAST_IDX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_table [4];
  logic [3:0]       r_vld;
  logic [WIDTH-1:0] r_key;
  logic [1:0]       r_idx;
  logic             r_hit;
  logic [1:0]       r_hit_idx;
  logic [2:0]       r_match_cnt;
  logic             r_wr_drop;

  logic w_idle;
  logic w_start;
  logic w_wr;
  logic w_inv;
  logic w_abort;
  logic w_chk_valid;
  logic w_xfer;
  logic w_step;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_idle & start;
  // inv_all takes priority over a simultaneous write
  assign w_inv   = w_idle & inv_all;
  assign w_wr    = w_idle & wr_en & ~inv_all;
  assign w_abort = (r_state == ST_SCAN) & abort;

  always_comb begin
    w_state_nxt = r_state;
    w_chk_valid = 1'b0;
    w_xfer      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          // invalid entries are skipped without offering them to the checker
          w_chk_valid = r_vld[r_idx];
          w_xfer      = r_vld[r_idx] & chk.chk_ready;
          w_step      = ~r_vld[r_idx] | chk.chk_ready;
          if (w_step && (r_idx == c_LAST_IDX)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_table[i] <= '0;
      end
      r_vld <= 4'b0000;
    end else if (w_inv) begin
      r_vld <= 4'b0000;
    end else if (w_wr) begin
      r_table[wr_idx] <= wr_data;
      r_vld[wr_idx]   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
      r_idx <= 2'd0;
    end else if (w_start) begin
      r_key <= key;
      r_idx <= 2'd0;
    end else if (w_step && (r_idx != c_LAST_IDX)) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit       <= 1'b0;
      r_hit_idx   <= 2'd0;
      r_match_cnt <= 3'd0;
    end else if (w_start || w_abort) begin
      r_hit       <= 1'b0;
      r_hit_idx   <= 2'd0;
      r_match_cnt <= 3'd0;
    end else if (w_xfer && chk.chk_match) begin
      r_match_cnt <= r_match_cnt + 3'd1;
      if (!r_hit) begin
        r_hit     <= 1'b1;
        r_hit_idx <= r_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= ~w_idle & (wr_en | inv_all);
    end
  end

  assign chk.sel       = r_idx;
  assign chk.ent_data  = r_table[r_idx];
  assign chk.key_out   = r_key;
  assign chk.chk_valid = w_chk_valid;

  assign busy      = ~w_idle;
  assign done      = (r_state == ST_DONE);
  assign hit       = r_hit;
  assign hit_idx   = r_hit_idx;
  assign match_cnt = r_match_cnt;
  assign wr_drop   = r_wr_drop;

endmodule
`default_nettype wire

// File: doc/entry_scan_ctrl.md
# entry_scan_ctrl

Sequential initiator that owns a 4-entry record table and drives it, one entry per handshake, into the downstream combinational entry checker. It steers the 2-bit entry select, presents the selected record and a latched key, and collects the per-entry match verdict. At the end of a scan it reports the first matching index and the total match count. It sits upstream of the checker and is the only writer of the table contents the checker compares.

## Interface
Parameters:
- WIDTH, 8, bit width of each table record and of the key

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  table write strobe
- wr_idx  in  2  table entry to write
- wr_data  in  WIDTH  record value to write
- inv_all  in  1  clears all four entry-valid bits
- start  in  1  begin a scan; samples key
- key  in  WIDTH  comparison key, latched on accepted start
- abort  in  1  cancel the scan in progress
- sel  out  2  entry index presented to the checker
- ent_data  out  WIDTH  record at sel
- key_out  out  WIDTH  latched key
- chk_valid  out  1  sel/ent_data/key_out are valid for checking
- chk_ready  in  1  checker accepts the current entry
- chk_match  in  1  checker verdict, qualified by chk_valid & chk_ready
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at scan completion
- hit  out  1  at least one entry matched in the last completed scan
- hit_idx  out  2  lowest matching index in the last completed scan
- match_cnt  out  3  number of matching entries, 0..4
- wr_drop  out  1  one-cycle pulse: write or inv_all ignored because busy

## Operation
- Storage: table[0..3] (WIDTH each) and vld[3:0].
- Write rules:
  - In IDLE, wr_en writes table[wr_idx]<=wr_data and sets vld[wr_idx].
  - In IDLE, inv_all clears vld to 0.
  - If wr_en and inv_all are both asserted, inv_all wins and no write happens.
  - In any other state, wr_en or inv_all is ignored and wr_drop pulses the next cycle.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On start: key_reg<=key, idx<=0, hit/hit_idx/match_cnt cleared to 0, go to SCAN.
  - If start and wr_en arrive together, the write is performed and the scan then sees the new contents.
- SCAN, with idx current:
  - If vld[idx]=0: chk_valid=0 and the entry is skipped in 1 cycle.
  - If vld[idx]=1: chk_valid=1, sel=idx, ent_data=table[idx], key_out=key_reg. These are held stable until chk_ready=1.
  - On a transfer (chk_valid & chk_ready): if chk_match=1, match_cnt increments; if hit was 0, hit<=1 and hit_idx<=idx.
  - After a skip or a transfer: if idx=3, go to DONE; otherwise idx increments.
- DONE: done=1 for one cycle, then go to IDLE. hit, hit_idx and match_cnt hold until the next accepted start.
- start while busy is ignored.
- abort in SCAN: go to IDLE next cycle with no done pulse and no transfer recorded that cycle; hit/hit_idx/match_cnt are cleared to 0. abort in IDLE or DONE has no effect.
- chk_match is ignored whenever chk_valid & chk_ready = 0.
- sel=idx in every state; ent_data=table[sel] combinationally; key_out=key_reg at all times.

## Timing
- Reset values: state IDLE, table 0, vld 0, key_reg 0, idx 0. Outputs: sel 0, ent_data 0, key_out 0, chk_valid 0, busy 0, done 0, hit 0, hit_idx 0, match_cnt 0, wr_drop 0.
- Reset asserted mid-scan returns to these values immediately, with no done pulse.
- Writes are visible on ent_data the cycle after wr_en.
- With start accepted at cycle 0 and chk_ready tied high, skipped and transferred entries each cost exactly 1 cycle: SCAN runs in cycles 1–4, done pulses in cycle 5, busy is high in cycles 1–5, and IDLE is reached in cycle 6. Every checker stall cycle adds 1 cycle.
- hit, hit_idx and match_cnt are final in the same cycle that done is high.
- A new start is accepted earliest in cycle 6.

## Test plan
- Write 0x11, 0x22, 0x33, 0x44 to entries 0–3; start with key 0x33; checker reports match when ent_data==key_out; chk_ready=1 -> chk_valid cycles 1–4 with sel 0..3; done in cycle 5; hit=1, hit_idx=2, match_cnt=1.
- Entries 0x5A, 0x00, 0x5A, 0x5A; key 0x5A -> hit_idx=0, match_cnt=3.
- Only entries 1 and 3 valid; chk_ready low for 2 cycles on entry 1 -> sel/ent_data held during the stall; entries 0 and 2 produce no chk_valid; done in cycle 7.
- wr_en and inv_all pulsed mid-scan -> wr_drop pulses, table and vld unchanged; start mid-scan ignored.
- abort during entry 2 -> no done pulse, IDLE next cycle, hit and match_cnt read 0; a subsequent start runs normally.
- rst asserted during SCAN -> all outputs return to reset values immediately; a scan after reset deasserts, with no writes, gives done in cycle 5 with hit=0 and match_cnt=0.
